// File: rtl/battle_datapath.sv
// Battle datapath: HP registers, LFSR-driven crit/AI move selection, and
// clamped/saturated damage calculation applied to the selected target.
module battle_datapath #(
  parameter int          HP_W      = 4,
  parameter int          P_MAX_HP  = 15,
  parameter int          AI_MAX_HP = 15,
  parameter int          P_ATK     = 2,
  parameter int          P_DEF     = 1,
  parameter int          AI_ATK    = 2,
  parameter int          AI_DEF    = 1,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            restore,
  input  logic [1:0]      p_move,
  input  logic            calc_damage,
  input  logic            active_trainer,
  input  logic            target,
  input  logic            apply_damage,
  output logic [HP_W-1:0] p_hp,
  output logic [HP_W-1:0] ai_hp,
  output logic            p_fainted,
  output logic            ai_fainted,
  output logic [HP_W-1:0] last_damage,
  output logic [1:0]      ai_move,
  output logic            crit
);

  localparam int RAW_W = HP_W + 3;
  localparam logic [HP_W-1:0]         DMG_MAX  = '1;
  localparam logic [HP_W-1:0]         P_MAX    = HP_W'(P_MAX_HP);
  localparam logic [HP_W-1:0]         AI_MAX   = HP_W'(AI_MAX_HP);
  localparam logic signed [RAW_W-1:0] RAW_ONE  = RAW_W'(1);
  localparam logic signed [RAW_W-1:0] RAW_MAX  = RAW_W'(DMG_MAX);
  localparam logic signed [RAW_W-1:0] P_ATK_S  = RAW_W'(P_ATK);
  localparam logic signed [RAW_W-1:0] P_DEF_S  = RAW_W'(P_DEF);
  localparam logic signed [RAW_W-1:0] AI_ATK_S = RAW_W'(AI_ATK);
  localparam logic signed [RAW_W-1:0] AI_DEF_S = RAW_W'(AI_DEF);

  function automatic logic [HP_W-1:0] clamp_raw(input logic signed [RAW_W-1:0] raw);
    if (raw < RAW_ONE)      clamp_raw = HP_W'(1);
    else if (raw > RAW_MAX) clamp_raw = DMG_MAX;
    else                    clamp_raw = raw[HP_W-1:0];
  endfunction

  function automatic logic [HP_W-1:0] crit_double(input logic [HP_W-1:0] d);
    logic [HP_W:0] dbl;
    dbl = {d, 1'b0};
    crit_double = dbl[HP_W] ? DMG_MAX : dbl[HP_W-1:0];
  endfunction

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                              input logic [HP_W-1:0] d);
    sat_sub = (d >= hp) ? '0 : hp - d;
  endfunction

  logic [7:0]      lfsr_q, lfsr_d;
  logic [HP_W-1:0] p_hp_q, p_hp_d, ai_hp_q, ai_hp_d;
  logic [HP_W-1:0] last_damage_q, last_damage_d;
  logic [1:0]      ai_move_q, ai_move_d;
  logic            crit_q, crit_d;

  logic [1:0]              move_sel;
  logic signed [RAW_W-1:0] atk_s, def_s, power_s, raw_s;
  logic [HP_W-1:0]         clamped, dmg_new;
  logic                    crit_hit;

  always_comb begin
    move_sel = active_trainer ? lfsr_q[1:0] : p_move;
    atk_s    = active_trainer ? AI_ATK_S : P_ATK_S;
    def_s    = active_trainer ? P_DEF_S  : AI_DEF_S;
    power_s  = $signed({{(RAW_W-2){1'b0}}, move_sel}) + RAW_ONE;
    raw_s    = power_s + atk_s - def_s;
    clamped  = clamp_raw(raw_s);
    crit_hit = &lfsr_q[7:5];
    dmg_new  = crit_hit ? crit_double(clamped) : clamped;
  end

  always_comb begin
    lfsr_d        = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    p_hp_d        = p_hp_q;
    ai_hp_d       = ai_hp_q;
    last_damage_d = last_damage_q;
    ai_move_d     = ai_move_q;
    crit_d        = crit_q;
    if (restore) begin
      p_hp_d        = P_MAX;
      ai_hp_d       = AI_MAX;
      last_damage_d = '0;
      crit_d        = 1'b0;
    end else begin
      // Apply reads the pre-edge damage, so a same-cycle calc never affects it.
      if (apply_damage) begin
        if (target) ai_hp_d = sat_sub(ai_hp_q, last_damage_q);
        else        p_hp_d  = sat_sub(p_hp_q, last_damage_q);
      end
      if (calc_damage) begin
        last_damage_d = dmg_new;
        crit_d        = crit_hit;
        if (active_trainer) ai_move_d = move_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr_q        <= LFSR_SEED;
      p_hp_q        <= P_MAX;
      ai_hp_q       <= AI_MAX;
      last_damage_q <= '0;
      ai_move_q     <= 2'd0;
      crit_q        <= 1'b0;
    end else begin
      lfsr_q        <= lfsr_d;
      p_hp_q        <= p_hp_d;
      ai_hp_q       <= ai_hp_d;
      last_damage_q <= last_damage_d;
      ai_move_q     <= ai_move_d;
      crit_q        <= crit_d;
    end
  end

  assign p_hp        = p_hp_q;
  assign ai_hp       = ai_hp_q;
  assign last_damage = last_damage_q;
  assign ai_move     = ai_move_q;
  assign crit        = crit_q;
  assign p_fainted   = (p_hp_q == '0);
  assign ai_fainted  = (ai_hp_q == '0);

endmodule

// File: tb/tb_battle_datapath.sv
// Bench for battle_datapath: three parameterisations share stimulus and are
// checked against an arithmetic reference model, directed tables and random turns.
module tb_battle_datapath;

  logic clk = 1'b0;
  logic reset_n = 1'b0, restore = 1'b0, calc = 1'b0, trainer = 1'b0;
  logic tgt = 1'b0, apply = 1'b0;
  logic [1:0] p_move = 2'd0;

  logic [3:0] o_php[3], o_aihp[3], o_dmg[3];
  logic [1:0] o_aim[3];
  logic       o_crit[3], o_pf[3], o_af[3];

  always #5 clk = ~clk;

  battle_datapath dut0 (.clk(clk), .reset_n(reset_n), .restore(restore), .p_move(p_move),
    .calc_damage(calc), .active_trainer(trainer), .target(tgt), .apply_damage(apply),
    .p_hp(o_php[0]), .ai_hp(o_aihp[0]), .p_fainted(o_pf[0]), .ai_fainted(o_af[0]),
    .last_damage(o_dmg[0]), .ai_move(o_aim[0]), .crit(o_crit[0]));

  battle_datapath #(.P_ATK(0), .AI_DEF(3)) dut1 (.clk(clk), .reset_n(reset_n),
    .restore(restore), .p_move(p_move), .calc_damage(calc), .active_trainer(trainer),
    .target(tgt), .apply_damage(apply), .p_hp(o_php[1]), .ai_hp(o_aihp[1]),
    .p_fainted(o_pf[1]), .ai_fainted(o_af[1]), .last_damage(o_dmg[1]),
    .ai_move(o_aim[1]), .crit(o_crit[1]));

  battle_datapath #(.P_ATK(7)) dut2 (.clk(clk), .reset_n(reset_n), .restore(restore),
    .p_move(p_move), .calc_damage(calc), .active_trainer(trainer), .target(tgt),
    .apply_damage(apply), .p_hp(o_php[2]), .ai_hp(o_aihp[2]), .p_fainted(o_pf[2]),
    .ai_fainted(o_af[2]), .last_damage(o_dmg[2]), .ai_move(o_aim[2]), .crit(o_crit[2]));

  int p_atk_t[3]  = '{2, 0, 7};
  int ai_def_t[3] = '{1, 3, 1};

  logic [7:0] m_lfsr;
  int m_php[3], m_aihp[3], m_dmg[3];
  int m_crit, m_aim;
  int total = 0, bad = 0;

  function automatic int mdmg(int mv, int atk, int def, bit c);
    int d;
    d = (mv + 1) + atk - def;
    if (d < 1) d = 1;
    if (d > 15) d = 15;
    if (c) d = (2 * d > 15) ? 15 : 2 * d;
    return d;
  endfunction

  // One clock of the reference model, evaluated from the inputs in force.
  task automatic cyc();
    logic [7:0] nl;
    int np[3], na[3], nd[3], nc, nm, mv;
    bit c;
    nl = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    np = m_php; na = m_aihp; nd = m_dmg; nc = m_crit; nm = m_aim;
    if (!reset_n) begin
      nl = 8'hA5; nc = 0; nm = 0;
      for (int k = 0; k < 3; k++) begin np[k] = 15; na[k] = 15; nd[k] = 0; end
    end else if (restore) begin
      nc = 0;
      for (int k = 0; k < 3; k++) begin np[k] = 15; na[k] = 15; nd[k] = 0; end
    end else begin
      c  = (m_lfsr[7:5] == 3'b111);
      mv = trainer ? int'(m_lfsr[1:0]) : int'(p_move);
      for (int k = 0; k < 3; k++) begin
        if (apply) begin
          if (tgt) na[k] = (m_aihp[k] > m_dmg[k]) ? m_aihp[k] - m_dmg[k] : 0;
          else     np[k] = (m_php[k]  > m_dmg[k]) ? m_php[k]  - m_dmg[k] : 0;
        end
        if (calc) nd[k] = trainer ? mdmg(mv, 2, 1, c) : mdmg(mv, p_atk_t[k], ai_def_t[k], c);
      end
      if (calc) begin
        nc = c;
        if (trainer) nm = mv;
      end
    end
    @(posedge clk); #1;
    m_lfsr = nl; m_php = np; m_aihp = na; m_dmg = nd; m_crit = nc; m_aim = nm;
  endtask

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic check_all(string nm);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.d%0d.p_hp", nm, k), int'(o_php[k]), m_php[k]);
      chk($sformatf("%s.d%0d.ai_hp", nm, k), int'(o_aihp[k]), m_aihp[k]);
      chk($sformatf("%s.d%0d.dmg", nm, k), int'(o_dmg[k]), m_dmg[k]);
      chk($sformatf("%s.d%0d.crit", nm, k), int'(o_crit[k]), m_crit);
      chk($sformatf("%s.d%0d.ai_move", nm, k), int'(o_aim[k]), m_aim);
      chk($sformatf("%s.d%0d.p_faint", nm, k), int'(o_pf[k]), int'(m_php[k] == 0));
      chk($sformatf("%s.d%0d.ai_faint", nm, k), int'(o_af[k]), int'(m_aihp[k] == 0));
    end
  endtask

  task automatic wait_lfsr(bit want);
    int n = 0;
    while (((m_lfsr[7:5] == 3'b111) != want) && n < 300) begin cyc(); n++; end
    chk("wait_lfsr", int'((m_lfsr[7:5] == 3'b111) == want), 1);
  endtask

  task automatic hit(int mv, bit want, bit tr, bit tg);
    wait_lfsr(want);
    p_move = 2'(mv); trainer = tr; calc = 1'b1;
    cyc();
    calc = 1'b0;
    check_all("hit_calc");
    apply = 1'b1; tgt = tg;
    cyc();
    apply = 1'b0;
    check_all("hit_apply");
  endtask

  task automatic check_defaults(string nm);
    chk({nm, ".p_hp"}, int'(o_php[0]), 15);
    chk({nm, ".ai_hp"}, int'(o_aihp[0]), 15);
    chk({nm, ".dmg"}, int'(o_dmg[0]), 0);
    chk({nm, ".crit"}, int'(o_crit[0]), 0);
    chk({nm, ".pf"}, int'(o_pf[0]), 0);
    chk({nm, ".af"}, int'(o_af[0]), 0);
  endtask

  typedef struct {
    int mv; bit want_crit; int d0; int d1; int d2;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t vt[6];
    int prev_hp, prev_dmg;
    logic [7:0] lc;
    vt[0] = '{3, 1'b0, 5, 1, 10};
    vt[1] = '{3, 1'b1, 10, 2, 15};
    vt[2] = '{0, 1'b0, 2, 1, 7};
    vt[3] = '{0, 1'b1, 4, 2, 14};
    vt[4] = '{1, 1'b0, 3, 1, 8};
    vt[5] = '{2, 1'b1, 8, 2, 15};

    reset_n = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
    check_defaults("reset");
    chk("reset.ai_move", int'(o_aim[0]), 0);
    check_all("reset");

    apply = 1'b1; tgt = 1'b1;
    cyc();
    apply = 1'b0;
    chk("apply_zero.ai_hp", int'(o_aihp[0]), 15);

    hit(3, 1'b0, 1'b0, 1'b1);
    chk("normal.dmg", int'(o_dmg[0]), 5);
    chk("normal.crit", int'(o_crit[0]), 0);
    chk("normal.ai_hp", int'(o_aihp[0]), 10);
    chk("normal.af", int'(o_af[0]), 0);

    for (int i = 0; i < 6; i++) begin
      wait_lfsr(vt[i].want_crit);
      p_move = 2'(vt[i].mv); trainer = 1'b0; calc = 1'b1;
      cyc();
      calc = 1'b0;
      chk($sformatf("tbl%0d.d0", i), int'(o_dmg[0]), vt[i].d0);
      chk($sformatf("tbl%0d.d1", i), int'(o_dmg[1]), vt[i].d1);
      chk($sformatf("tbl%0d.d2", i), int'(o_dmg[2]), vt[i].d2);
      chk($sformatf("tbl%0d.crit", i), int'(o_crit[0]), int'(vt[i].want_crit));
      check_all($sformatf("tbl%0d", i));
    end

    restore = 1'b1;
    cyc();
    restore = 1'b0;
    check_defaults("restore1");
    hit(3, 1'b0, 1'b0, 1'b1);
    hit(3, 1'b0, 1'b0, 1'b1);
    hit(0, 1'b0, 1'b0, 1'b1);
    chk("sat.ai_hp3", int'(o_aihp[0]), 3);
    hit(3, 1'b0, 1'b0, 1'b1);
    chk("sat.ai_hp0", int'(o_aihp[0]), 0);
    chk("sat.af", int'(o_af[0]), 1);
    apply = 1'b1; tgt = 1'b1;
    cyc();
    apply = 1'b0;
    chk("sat.again", int'(o_aihp[0]), 0);

    for (int i = 0; i < 4; i++) begin
      lc = m_lfsr;
      prev_hp = int'(o_php[0]);
      trainer = 1'b1; calc = 1'b1;
      cyc();
      calc = 1'b0;
      chk("ai.move", int'(o_aim[0]), int'(lc[1:0]));
      check_all("ai_calc");
      prev_dmg = int'(o_dmg[0]);
      apply = 1'b1; tgt = 1'b0;
      cyc();
      apply = 1'b0;
      chk("ai.p_hp", int'(o_php[0]), (prev_hp > prev_dmg) ? prev_hp - prev_dmg : 0);
    end

    restore = 1'b1;
    cyc();
    restore = 1'b0;
    wait_lfsr(1'b0);
    p_move = 2'd3; trainer = 1'b0; calc = 1'b1;
    cyc();
    wait_lfsr(1'b0);
    p_move = 2'd0; calc = 1'b1; apply = 1'b1; tgt = 1'b1;
    cyc();
    calc = 1'b0; apply = 1'b0;
    chk("simul.ai_hp", int'(o_aihp[0]), 10);
    chk("simul.dmg", int'(o_dmg[0]), 2);
    check_all("simul");

    lc = {6'd0, o_aim[0]};
    restore = 1'b1;
    cyc();
    restore = 1'b0;
    check_defaults("restore2");
    chk("restore2.ai_move", int'(o_aim[0]), int'(lc[1:0]));

    hit(3, 1'b0, 1'b0, 1'b1);
    trainer = 1'b1; calc = 1'b1;
    cyc();
    calc = 1'b0; apply = 1'b1; tgt = 1'b0; reset_n = 1'b0;
    cyc();
    apply = 1'b0; reset_n = 1'b1;
    check_defaults("midreset");
    chk("midreset.ai_move", int'(o_aim[0]), 0);
    check_all("midreset");

    for (int i = 0; i < 400; i++) begin
      calc    = 1'($urandom_range(0, 1));
      apply   = 1'($urandom_range(0, 1));
      trainer = 1'($urandom_range(0, 1));
      tgt     = 1'($urandom_range(0, 1));
      p_move  = 2'($urandom_range(0, 3));
      restore = ($urandom_range(0, 31) == 0);
      cyc();
      check_all("rand");
    end
    calc = 1'b0; apply = 1'b0; restore = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
